// File: rtl/text_writer.sv
// text_writer: decodes a byte stream of characters and cursor/color commands
// into single-cycle {color, glyph} writes to the 80x60 text RAM.
`default_nettype none

module text_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int ADDR_W = $clog2(COLS * ROWS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [7:0]                i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic                      o_we,
  output logic [ADDR_W-1:0]         o_waddr,
  output logic [7:0]                o_wdata,
  output logic [$clog2(COLS)-1:0]   o_cur_col,
  output logic [$clog2(ROWS)-1:0]   o_cur_row
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [1:0]          color_q, color_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [7:0]          wdata_q, wdata_d;

  logic                accept;
  logic [ADDR_W-1:0]   cell_addr;
  logic [ROW_W-1:0]    row_inc;

  assign o_ready   = (state_q == S_IDLE) && !i_rst;
  assign accept    = i_valid && o_ready;
  assign cell_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  assign row_inc   = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    color_d = color_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (i_data[7:6] == 2'b00) begin
            we_d    = 1'b1;
            waddr_d = cell_addr;
            wdata_d = {color_q, i_data[5:0]};
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_inc;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else if (i_data[7]) begin
            case (i_data[6:4])
              3'b000: color_d = i_data[1:0];
              3'b001: begin
                col_d = '0;
                row_d = row_inc;
              end
              3'b010: col_d = '0;
              3'b011: begin
                col_d = '0;
                row_d = '0;
              end
              3'b100: begin
                // First fill write goes out now; waddr_q then doubles as the fill counter.
                state_d = S_CLEAR;
                we_d    = 1'b1;
                waddr_d = '0;
                wdata_d = {color_q, 6'd0};
                col_d   = '0;
                row_d   = '0;
              end
              3'b101: begin
                if (col_q != '0) col_d = col_q - 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      S_CLEAR: begin
        if (waddr_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end else begin
          we_d    = 1'b1;
          waddr_d = waddr_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      color_q <= 2'b00;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      color_q <= color_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_we      = we_q;
  assign o_waddr   = waddr_q;
  assign o_wdata   = wdata_q;
  assign o_cur_col = col_q;
  assign o_cur_row = row_q;

endmodule

`default_nettype wire

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: expected RAM writes are queued at issue time
// and popped by an independent monitor on every write strobe.
`default_nettype none

module tb_text_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;
  localparam int NCELL  = COLS * ROWS;

  logic              clk;
  logic              rst;
  logic [7:0]        i_data;
  logic              i_valid;
  logic              o_ready;
  logic              o_we;
  logic [ADDR_W-1:0] o_waddr;
  logic [7:0]        o_wdata;
  logic [6:0]        o_cur_col;
  logic [5:0]        o_cur_row;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_we      (o_we),
    .o_waddr   (o_waddr),
    .o_wdata   (o_wdata),
    .o_cur_col (o_cur_col),
    .o_cur_row (o_cur_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+7:0] exp_q[$];

  int         m_col;
  int         m_row;
  logic [1:0] m_color;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_write(input int addr, input logic [7:0] data);
    exp_q.push_back({ADDR_W'(addr), data});
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (o_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write", o_waddr, o_wdata);
      end else begin
        logic [ADDR_W+7:0] e;
        e = exp_q.pop_front();
        if ({o_waddr, o_wdata} !== e) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   o_waddr, o_wdata, e[ADDR_W+7:8], e[7:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int g;
    g = 0;
    i_data  = b;
    i_valid = 1'b1;
    while (o_ready !== 1'b1) begin
      if (g > 6000) begin
        bad++;
        total++;
        $display("FAIL ready_timeout: got o_ready=0 for %0d cycles, required 1", g);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
      end
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // Update reference model, queue expected writes, send, then check strobe and cursor.
  task automatic issue(input logic [7:0] b);
    logic exp_we;
    exp_we = 1'b0;
    if (b[7:6] == 2'b00) begin
      push_write(m_row * COLS + m_col, {m_color, b[5:0]});
      exp_we = 1'b1;
      if (m_col == COLS - 1) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
      end else begin
        m_col++;
      end
    end else if (b[7]) begin
      case (b[6:4])
        3'd0: m_color = b[1:0];
        3'd1: begin m_col = 0; m_row = (m_row + 1) % ROWS; end
        3'd2: m_col = 0;
        3'd3: begin m_col = 0; m_row = 0; end
        3'd4: begin
          for (int k = 0; k < NCELL; k++) push_write(k, {m_color, 6'd0});
          m_col  = 0;
          m_row  = 0;
          exp_we = 1'b1;
        end
        3'd5: if (m_col > 0) m_col--;
        default: ;
      endcase
    end
    send(b);
    chk($sformatf("we_after_%02h", b), int'(o_we), int'(exp_we));
    chk($sformatf("col_after_%02h", b), int'(o_cur_col), m_col);
    chk($sformatf("row_after_%02h", b), int'(o_cur_row), m_row);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

  initial begin
    int cnt;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    m_col   = 0;
    m_row   = 0;
    m_color = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    chk("ready_in_reset", int'(o_ready), 0);
    rst = 1'b0;
    #1;
    chk("reset_we", int'(o_we), 0);
    chk("reset_waddr", int'(o_waddr), 0);
    chk("reset_wdata", int'(o_wdata), 0);
    chk("reset_col", int'(o_cur_col), 0);
    chk("reset_row", int'(o_cur_row), 0);
    chk("reset_ready", int'(o_ready), 1);

    // Back-to-back characters
    issue(8'h01);
    issue(8'h02);

    // Color change then character: {10, 111111} = 0xBF
    issue(8'h82);
    issue(8'h3F);

    // Backspace, CR, reserved and unused opcodes
    issue(8'hB0);
    issue(8'hD0);
    issue(8'h01);
    issue(8'h01);
    issue(8'h01);
    issue(8'hD0);
    issue(8'h90);
    issue(8'h01);
    issue(8'hA0);
    issue(8'h45);
    issue(8'hE0);

    // Last cell and wrap to origin
    issue(8'hB0);
    for (int i = 0; i < ROWS - 1; i++) issue(8'h90);
    for (int i = 0; i < COLS - 1; i++) issue(8'h01);
    chk("corner_col", int'(o_cur_col), 79);
    chk("corner_row", int'(o_cur_row), 59);
    issue(8'h05);

    // Full clear with color 1 and a following byte held valid
    issue(8'h81);
    issue(8'hC0);
    i_data  = 8'h07;
    i_valid = 1'b1;
    cnt = 0;
    while (o_ready !== 1'b1 && cnt < 6000) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("clear_ready_low_cycles", cnt, NCELL);
    chk("clear_queue_drained", exp_q.size(), 0);
    issue(8'h07);

    // Reset in the middle of a clear
    issue(8'hB0);
    for (int k = 0; k < 100; k++) push_write(k, {m_color, 6'd0});
    send(8'hC0);
    repeat (99) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_we", int'(o_we), 0);
    chk("abort_col", int'(o_cur_col), 0);
    chk("abort_row", int'(o_cur_row), 0);
    chk("abort_ready_in_reset", int'(o_ready), 0);
    rst = 1'b0;
    m_col   = 0;
    m_row   = 0;
    m_color = 2'b00;
    #1;
    chk("abort_ready_after", int'(o_ready), 1);
    issue(8'h03);

    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
